tb_data_bus_router: RTL and testbench
=====================================

Name: tb_data_bus_router

Overview:
- Parametrised demultiplexer for the core data port in the RedMulE testbench. Replaces the fixed periph/stack/tcdm/"other" steering.
- Routes each core request (req/gnt/rvalid protocol) to one of NT address-decoded targets, an internal mailbox, or an internal error slave.
- Enforces in-order responses by tracking outstanding transactions.
- Exposes end-of-test status (exit code, putchar stream) and read/write handshake counters to the bench.

Parameters:
- NT, 3, number of external targets (1..8)
- MAX_OUT, 2, max outstanding transactions (1..15)
- REGION_BASE, {32'h1C010000,32'h00000000,32'h00100000}, packed [NT][32] base per target
- REGION_MASK, {32'hFF000000,32'hFF000000,32'hFFF00000}, packed [NT][32] compare mask per target
- MBOX_BASE, 32'h80000000, mailbox base; mailbox decodes when addr[31:4]==MBOX_BASE[31:4]
- ERR_RDATA, 32'hBADACCE5, rdata returned by the error slave

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- req_i  in  1  core request
- gnt_o  out  1  grant to core
- addr_i  in  32  byte address
- we_i  in  1  1 = write
- be_i  in  4  byte enables
- wdata_i  in  32  write data
- rvalid_o  out  1  response valid
- rdata_o  out  32  response data
- err_o  out  1  response error, qualified by rvalid_o
- tgt_req_o  out  NT  per-target request
- tgt_add_o  out  NT*32  address, broadcast
- tgt_wen_o  out  NT  active-low write enable (1 = read)
- tgt_be_o  out  NT*4  byte enables
- tgt_data_o  out  NT*32  write data
- tgt_gnt_i  in  NT  target grant
- tgt_r_data_i  in  NT*32  target read data
- tgt_r_valid_i  in  NT  target response valid
- exit_valid_o  out  1  sticky; set on a write to MBOX_BASE+0
- exit_code_o  out  32  last value written to MBOX_BASE+0
- putc_valid_o  out  1  one-cycle pulse per write to MBOX_BASE+4
- putc_data_o  out  8  wdata_i[7:0] of that write
- protocol_err_o  out  1  sticky; spurious response seen
- cnt_rd_o  out  32  granted reads, all destinations
- cnt_wr_o  out  32  granted writes, all destinations

Behaviour:
- Decode (combinational), priority order:
  - mailbox;
  - else lowest index i with (addr_i & REGION_MASK[i]) == (REGION_BASE[i] & REGION_MASK[i]);
  - else error slave.
  - dest id width is $clog2(NT+2).
- Outstanding tracker: count cnt (0..MAX_OUT) and cur_dest register.
- Issue rule: a request may issue iff cnt==0, or (cnt<MAX_OUT and dest==cur_dest). Otherwise it stalls: gnt_o=0 and no tgt_req_o asserted.
- While issuable, tgt_req_o[dest]=req_i; all other tgt_req_o bits are 0.
- gnt_o:
  - external dest: tgt_gnt_i[dest];
  - internal dest: 1 in the same cycle.
- Handshake = req_i & gnt_o. On a handshake: cnt++ and cur_dest<=dest.
- Response on external dest: tgt_r_valid_i[cur_dest] with cnt>0 gives rvalid_o=1, rdata_o=tgt_r_data_i[cur_dest], err_o=0. cnt-- on that response.
- Simultaneous handshake and response: cnt unchanged.
- Internal slaves (mailbox, error slave):
  - latency exactly 1 cycle, one response per handshake; pipelined back-to-back issue is allowed.
  - Error slave response: rdata=ERR_RDATA, err_o=1.
  - Mailbox read: offset 0 returns exit_code; every other offset returns 0. err_o=0.
- Spurious response: tgt_r_valid_i[j] with j!=cur_dest, or with cnt==0. Not forwarded, cnt unchanged, protocol_err_o<=1.
- Mailbox writes, on the handshake edge:
  - offset 0: exit_code<=wdata_i, exit_valid<=1;
  - offset 4: putc_valid_o=1 in the next cycle with putc_data_o.
  - Other offsets are ignored.
- Counters: cnt_rd_o/cnt_wr_o increment on each handshake with we_i=0/1. 32-bit wrap from FFFFFFFF to 0.
- Response outputs are driven 0 when rvalid_o=0.
- Reset (asynchronous, mid-transaction allowed):
  - cnt=0, cur_dest=0;
  - every output 0: gnt_o and tgt_req_o follow with cnt=0, and rvalid/err/putc/exit/protocol_err/counters are all 0;
  - exit_code_o=0.
  - In-flight responses arriving after reset count as spurious.

Test Plan:
- Read 0x1C010010 with target0 gnt same cycle and r_valid 1 cycle later with data 0xDEADBEEF -> tgt_req_o=3'b001, rvalid_o with rdata_o=DEADBEEF, err_o=0, cnt_rd_o=1.
- Write 0x00000040 then immediate read 0x1C010000 while target1 delays its response 3 cycles -> second request stalls (gnt_o=0, tgt_req_o=0) until target1 responds, then issues to target0.
- Three back-to-back reads to target0, MAX_OUT=2, target0 response delayed -> third request stalls until the first response; responses arrive in order.
- Read 0x40000000 (unmapped) -> gnt same cycle, next cycle rvalid_o=1, rdata_o=BADACCE5, err_o=1.
- Write 0x80000004 data 0x41, then write 0x80000000 data 0 -> putc pulse with 0x41, then exit_valid_o=1, exit_code_o=0, cnt_wr_o=2.
- Pulse tgt_r_valid_i[2] with cnt=0 -> protocol_err_o=1, no rvalid_o. Assert rst_n=0 with 2 outstanding -> all outputs 0 and cnt cleared.

Source files
------------

// File: rtl/tb_data_bus_router.sv
// tb_data_bus_router: address-decoded demux of the core data port onto NT targets, a mailbox and an error slave,
// keeping responses in order by only letting a new destination issue once the previous one has drained.
module tb_data_bus_router #(
  parameter int                     NT          = 3,
  parameter int                     MAX_OUT     = 2,
  parameter logic [0:NT-1][31:0]    REGION_BASE = {32'h1C010000, 32'h00000000, 32'h00100000},
  parameter logic [0:NT-1][31:0]    REGION_MASK = {32'hFF000000, 32'hFF000000, 32'hFFF00000},
  parameter logic [31:0]            MBOX_BASE   = 32'h80000000,
  parameter logic [31:0]            ERR_RDATA   = 32'hBADACCE5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_i,
  output logic             gnt_o,
  input  logic [31:0]      addr_i,
  input  logic             we_i,
  input  logic [3:0]       be_i,
  input  logic [31:0]      wdata_i,
  output logic             rvalid_o,
  output logic [31:0]      rdata_o,
  output logic             err_o,
  output logic [NT-1:0]    tgt_req_o,
  output logic [NT*32-1:0] tgt_add_o,
  output logic [NT-1:0]    tgt_wen_o,
  output logic [NT*4-1:0]  tgt_be_o,
  output logic [NT*32-1:0] tgt_data_o,
  input  logic [NT-1:0]    tgt_gnt_i,
  input  logic [NT*32-1:0] tgt_r_data_i,
  input  logic [NT-1:0]    tgt_r_valid_i,
  output logic             exit_valid_o,
  output logic [31:0]      exit_code_o,
  output logic             putc_valid_o,
  output logic [7:0]       putc_data_o,
  output logic             protocol_err_o,
  output logic [31:0]      cnt_rd_o,
  output logic [31:0]      cnt_wr_o
);
  localparam int DW = $clog2(NT + 2);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [DW-1:0] MBOX_ID = DW'(NT);
  localparam logic [DW-1:0] ERR_ID  = DW'(NT + 1);

  logic [DW-1:0] dest, cur_dest_q, cur_dest_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NT-1:0] dest_oh, cur_oh;
  logic          mbox, ext, issue, hs, ext_rsp, rsp, spur, wr_exit, wr_putc;
  logic [31:0]   ext_rdata, int_rdata_d, int_rdata_q;
  logic          int_vld_q, int_err_q;
  logic          exit_valid_q, putc_valid_q, perr_q;
  logic [31:0]   exit_code_q, cnt_rd_q, cnt_wr_q;
  logic [7:0]    putc_data_q;

  always_comb begin
    mbox = addr_i[31:4] == MBOX_BASE[31:4];
    dest = ERR_ID;
    // Descending scan so the lowest matching region wins.
    for (int i = NT - 1; i >= 0; i--)
      if ((addr_i & REGION_MASK[i]) == (REGION_BASE[i] & REGION_MASK[i])) dest = DW'(i);
    dest = mbox ? MBOX_ID : dest;
    ext_rdata = '0;
    for (int i = 0; i < NT; i++) begin
      dest_oh[i] = dest == DW'(i);
      cur_oh[i]  = cur_dest_q == DW'(i);
      ext_rdata  = ext_rdata | (cur_oh[i] ? tgt_r_data_i[i*32 +: 32] : 32'h0);
    end
    ext         = |dest_oh;
    issue       = cnt_q == '0 || (cnt_q < CW'(MAX_OUT) && dest == cur_dest_q);
    gnt_o       = req_i & issue & (ext ? |(tgt_gnt_i & dest_oh) : 1'b1);
    tgt_req_o   = {NT{req_i & issue}} & dest_oh;
    hs          = req_i & gnt_o;
    ext_rsp     = cnt_q != '0 && |(tgt_r_valid_i & cur_oh);
    // Any valid outside the single expected target (or with nothing outstanding) is dropped.
    spur        = |(tgt_r_valid_i & ~({NT{cnt_q != '0}} & cur_oh));
    rsp         = ext_rsp | int_vld_q;
    cnt_d       = cnt_q + CW'(hs) - CW'(rsp);
    cur_dest_d  = hs ? dest : cur_dest_q;
    wr_exit     = hs & mbox & we_i & (addr_i[3:0] == 4'h0);
    wr_putc     = hs & mbox & we_i & (addr_i[3:0] == 4'h4);
    int_rdata_d = !mbox ? ERR_RDATA : (!we_i && addr_i[3:0] == 4'h0) ? exit_code_q : 32'h0;
  end

  assign tgt_add_o      = {NT{addr_i}};
  assign tgt_wen_o      = {NT{~we_i}};
  assign tgt_be_o       = {NT{be_i}};
  assign tgt_data_o     = {NT{wdata_i}};
  assign rvalid_o       = rsp;
  assign rdata_o        = ext_rsp ? ext_rdata : int_vld_q ? int_rdata_q : 32'h0;
  assign err_o          = int_vld_q & int_err_q & ~ext_rsp;
  assign exit_valid_o   = exit_valid_q;
  assign exit_code_o    = exit_code_q;
  assign putc_valid_o   = putc_valid_q;
  assign putc_data_o    = putc_data_q;
  assign protocol_err_o = perr_q;
  assign cnt_rd_o       = cnt_rd_q;
  assign cnt_wr_o       = cnt_wr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      cur_dest_q   <= '0;
      int_vld_q    <= 1'b0;
      int_err_q    <= 1'b0;
      int_rdata_q  <= '0;
      exit_valid_q <= 1'b0;
      exit_code_q  <= '0;
      putc_valid_q <= 1'b0;
      putc_data_q  <= '0;
      perr_q       <= 1'b0;
      cnt_rd_q     <= '0;
      cnt_wr_q     <= '0;
    end else begin
      cnt_q        <= cnt_d;
      cur_dest_q   <= cur_dest_d;
      int_vld_q    <= hs & ~ext;
      int_err_q    <= ~mbox;
      int_rdata_q  <= int_rdata_d;
      exit_valid_q <= exit_valid_q | wr_exit;
      exit_code_q  <= wr_exit ? wdata_i : exit_code_q;
      putc_valid_q <= wr_putc;
      putc_data_q  <= wr_putc ? wdata_i[7:0] : 8'h0;
      perr_q       <= perr_q | spur;
      cnt_rd_q     <= cnt_rd_q + 32'(hs & ~we_i);
      cnt_wr_q     <= cnt_wr_q + 32'(hs & we_i);
    end
  end
endmodule

// File: tb/tb_tb_data_bus_router.sv
// tb_tb_data_bus_router: directed vectors against the data bus router with hand-computed expectations.
module tb_tb_data_bus_router;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_i, we_i;
  logic [31:0] addr_i, wdata_i;
  logic [3:0]  be_i;
  logic        gnt_o, rvalid_o, err_o;
  logic [31:0] rdata_o;
  logic [2:0]  tgt_req_o, tgt_wen_o, tgt_gnt_i, tgt_r_valid_i;
  logic [95:0] tgt_add_o, tgt_data_o, tgt_r_data_i;
  logic [11:0] tgt_be_o;
  logic        exit_valid_o, putc_valid_o, protocol_err_o;
  logic [31:0] exit_code_o, cnt_rd_o, cnt_wr_o;
  logic [7:0]  putc_data_o;
  int n_chk = 0;
  int n_err = 0;

  tb_data_bus_router dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i),
    .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .tgt_req_o(tgt_req_o), .tgt_add_o(tgt_add_o), .tgt_wen_o(tgt_wen_o), .tgt_be_o(tgt_be_o),
    .tgt_data_o(tgt_data_o), .tgt_gnt_i(tgt_gnt_i), .tgt_r_data_i(tgt_r_data_i),
    .tgt_r_valid_i(tgt_r_valid_i), .exit_valid_o(exit_valid_o), .exit_code_o(exit_code_o),
    .putc_valid_o(putc_valid_o), .putc_data_o(putc_data_o), .protocol_err_o(protocol_err_o),
    .cnt_rd_o(cnt_rd_o), .cnt_wr_o(cnt_wr_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // One cycle of stimulus applied at the falling edge; only responding targets carry rd, others carry junk.
  task automatic cyc(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] g, input logic [2:0] v, input logic [31:0] rd);
    @(negedge clk);
    req_i = r; we_i = w; addr_i = a; wdata_i = d; tgt_gnt_i = g; tgt_r_valid_i = v;
    for (int j = 0; j < 3; j++) tgt_r_data_i[j*32 +: 32] = v[j] ? rd : (32'hEE000000 | 32'(j));
    #1;
  endtask

  initial begin
    rst_n = 1'b1; req_i = 0; we_i = 0; addr_i = 0; wdata_i = 0; be_i = 4'hF;
    tgt_gnt_i = 0; tgt_r_valid_i = 0; tgt_r_data_i = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_gnt", gnt_o, 0);
    check("rst_req", tgt_req_o, 0);
    check("rst_rvalid", rvalid_o, 0);
    check("rst_exit", {exit_valid_o, putc_valid_o, protocol_err_o}, 0);
    check("rst_code", exit_code_o, 0);
    check("rst_cnt", cnt_rd_o | cnt_wr_o, 0);
    @(negedge clk) rst_n = 1'b1;
    // single read to target0
    cyc(1, 0, 32'h1C010010, 0, 3'b001, 3'b000, 0);
    check("t1_req", tgt_req_o, 3'b001);
    check("t1_gnt", gnt_o, 1);
    cyc(0, 0, 0, 0, 3'b000, 3'b001, 32'hDEADBEEF);
    check("t1_rvalid", rvalid_o, 1);
    check("t1_rdata", rdata_o, 32'hDEADBEEF);
    check("t1_err", err_o, 0);
    check("t1_cntrd", cnt_rd_o, 1);
    cyc(0, 0, 0, 0, 3'b000, 3'b000, 0);
    check("t1_idle", {rvalid_o, rdata_o}, 0);
    // write target1, then read target0 stalls until target1 drains
    cyc(1, 1, 32'h00000040, 32'h11, 3'b010, 3'b000, 0);
    check("t2_req", tgt_req_o, 3'b010);
    check("t2_gnt", gnt_o, 1);
    cyc(1, 0, 32'h1C010000, 0, 3'b001, 3'b000, 0);
    check("t2_stall1", {gnt_o, tgt_req_o}, 0);
    cyc(1, 0, 32'h1C010000, 0, 3'b001, 3'b000, 0);
    check("t2_stall2", {gnt_o, tgt_req_o}, 0);
    cyc(1, 0, 32'h1C010000, 0, 3'b001, 3'b010, 32'h0);
    check("t2_rsp1", rvalid_o, 1);
    check("t2_stall3", {gnt_o, tgt_req_o}, 0);
    cyc(1, 0, 32'h1C010000, 0, 3'b001, 3'b000, 0);
    check("t2_issue", {gnt_o, tgt_req_o}, 4'b1001);
    cyc(0, 0, 0, 0, 3'b000, 3'b001, 32'h12345678);
    check("t2_rdata", rdata_o, 32'h12345678);
    check("t2_cntwr", cnt_wr_o, 1);
    // three reads to target0 with MAX_OUT=2
    cyc(1, 0, 32'h1C010100, 0, 3'b001, 3'b000, 0);
    check("t3_gnt1", gnt_o, 1);
    cyc(1, 0, 32'h1C010100, 0, 3'b001, 3'b000, 0);
    check("t3_gnt2", gnt_o, 1);
    cyc(1, 0, 32'h1C010100, 0, 3'b001, 3'b000, 0);
    check("t3_full", {gnt_o, tgt_req_o}, 0);
    cyc(1, 0, 32'h1C010100, 0, 3'b001, 3'b001, 32'hA1);
    check("t3_rd1", {rvalid_o, rdata_o}, {1'b1, 32'hA1});
    check("t3_full2", gnt_o, 0);
    cyc(1, 0, 32'h1C010100, 0, 3'b001, 3'b000, 0);
    check("t3_gnt3", gnt_o, 1);
    cyc(0, 0, 0, 0, 3'b000, 3'b001, 32'hA2);
    check("t3_rd2", {rvalid_o, rdata_o}, {1'b1, 32'hA2});
    cyc(0, 0, 0, 0, 3'b000, 3'b001, 32'hA3);
    check("t3_rd3", {rvalid_o, rdata_o}, {1'b1, 32'hA3});
    cyc(0, 0, 0, 0, 3'b000, 3'b000, 0);
    check("t3_cntrd", cnt_rd_o, 5);
    // unmapped read hits the error slave
    cyc(1, 0, 32'h40000000, 0, 3'b000, 3'b000, 0);
    check("t4_gnt", {gnt_o, tgt_req_o}, 4'b1000);
    cyc(0, 0, 0, 0, 3'b000, 3'b000, 0);
    check("t4_rsp", {rvalid_o, err_o, rdata_o}, {2'b11, 32'hBADACCE5});
    // mailbox putchar then exit
    cyc(1, 1, 32'h80000004, 32'h41, 3'b000, 3'b000, 0);
    check("t5_gnt", gnt_o, 1);
    cyc(1, 1, 32'h80000000, 32'h0, 3'b000, 3'b000, 0);
    check("t5_putc", {putc_valid_o, putc_data_o}, {1'b1, 8'h41});
    check("t5_wrsp", {rvalid_o, err_o, rdata_o}, {2'b10, 32'h0});
    check("t5_gnt2", gnt_o, 1);
    check("t5_noexit", exit_valid_o, 0);
    cyc(0, 0, 0, 0, 3'b000, 3'b000, 0);
    check("t5_putc_off", putc_valid_o, 0);
    check("t5_exit", {exit_valid_o, exit_code_o}, {1'b1, 32'h0});
    check("t5_cntwr", cnt_wr_o, 3);
    // exit code readback
    cyc(1, 1, 32'h80000000, 32'hCAFE0001, 3'b000, 3'b000, 0);
    cyc(1, 0, 32'h80000000, 0, 3'b000, 3'b000, 0);
    check("t5_rdgnt", gnt_o, 1);
    cyc(0, 0, 0, 0, 3'b000, 3'b000, 0);
    check("t5_rdback", {rvalid_o, err_o, rdata_o}, {2'b10, 32'hCAFE0001});
    check("t5_code", exit_code_o, 32'hCAFE0001);
    check("t5_cnts", {cnt_rd_o, cnt_wr_o}, {32'd7, 32'd4});
    // spurious response with nothing outstanding
    cyc(0, 0, 0, 0, 3'b000, 3'b100, 32'h77);
    check("t6_spur_fwd", rvalid_o, 0);
    cyc(1, 0, 32'h1C010000, 0, 3'b001, 3'b000, 0);
    check("t6_perr", protocol_err_o, 1);
    check("t6_gnt1", gnt_o, 1);
    cyc(1, 0, 32'h1C010000, 0, 3'b001, 3'b000, 0);
    check("t6_gnt2", gnt_o, 1);
    cyc(0, 0, 0, 0, 3'b000, 3'b000, 0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_flags", {exit_valid_o, putc_valid_o, protocol_err_o, rvalid_o, gnt_o}, 0);
    check("t6_rst_code", exit_code_o, 0);
    check("t6_rst_cnt", cnt_rd_o | cnt_wr_o, 0);
    @(negedge clk) rst_n = 1'b1;
    cyc(0, 0, 0, 0, 3'b000, 3'b001, 32'h99);
    check("t6_inflight", rvalid_o, 0);
    cyc(1, 0, 32'h00000040, 0, 3'b010, 3'b000, 0);
    check("t6_perr2", protocol_err_o, 1);
    check("t6_cleared", {gnt_o, tgt_req_o}, 4'b1010);
    cyc(0, 0, 0, 0, 3'b000, 3'b010, 32'h55);
    check("t6_rsp", {rvalid_o, rdata_o}, {1'b1, 32'h55});
    check("t6_cntrd", cnt_rd_o, 1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
